// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction-fetch front end.
package rv32i_types;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_RESET_VAL = 32'h4000_0060;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(32'h3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small packet FIFO with first-word fall-through head and single-edge flush.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_pkt_t       push_pkt,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_pkt_t       head
);

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) begin
                mem_q[wr_ptr_q] <= push_pkt;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, talks to imem, buffers packets.
// Optional FETCH_PERF_CNT_EN adds fetch_count/drop_count response counters.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET_VAL,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] drop_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      imem_address_q;
    logic             imem_read_q;

    logic [31:0]      redirect_tgt;
    logic             slot_free;
    logic             resp_keep;
    logic             resp_drop;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_pkt_t       push_pkt;
    fetch_pkt_t       fifo_head;

    assign redirect_tgt = align_pc(redirect_pc);

    // Only one request is ever in flight, so a free slot now is still free at response time.
    assign slot_free  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign resp_keep  = (state_q == FETCH_WAIT) && imem_resp && !redirect_valid;
    assign resp_drop  = imem_resp &&
                        ((state_q == FETCH_DROP) || ((state_q == FETCH_WAIT) && redirect_valid));
    assign fifo_pop   = !fifo_empty && if_ready && !redirect_valid;
    assign fifo_push  = resp_keep && (!fifo_full || fifo_pop);
    assign fifo_flush = redirect_valid;

    always_comb begin
        push_pkt       = '0;
        push_pkt.pc    = fetch_pc_q;
        push_pkt.instr = imem_rdata;
    end

    fetch_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_pkt (push_pkt),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    // Request FSM; a request once issued is always held until its response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH_IDLE;
            fetch_pc_q     <= RESET_PC;
            imem_read_q    <= 1'b0;
            imem_address_q <= RESET_PC;
        end else begin
            unique case (state_q)
                FETCH_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                    end else if (slot_free) begin
                        state_q        <= FETCH_WAIT;
                        imem_read_q    <= 1'b1;
                        imem_address_q <= fetch_pc_q;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_resp) begin
                        state_q     <= FETCH_IDLE;
                        imem_read_q <= 1'b0;
                        fetch_pc_q  <= redirect_valid ? redirect_tgt : fetch_pc_q + PC_STEP;
                    end else if (redirect_valid) begin
                        state_q    <= FETCH_DROP;
                        fetch_pc_q <= redirect_tgt;
                    end
                end
                FETCH_DROP: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                    end
                    if (imem_resp) begin
                        state_q     <= FETCH_IDLE;
                        imem_read_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= FETCH_IDLE;
                    imem_read_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_read    = imem_read_q;
    assign imem_address = imem_address_q;
    assign if_valid     = !fifo_empty;
    assign if_pc        = fifo_head.pc;
    assign if_instr     = fifo_head.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (fifo_push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (resp_drop) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign drop_count  = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h4000_0060;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    // Model: expected packets, next fetch address, the one outstanding request.
    logic [63:0] m_q[$];
    logic [31:0] m_next_pc;
    logic        m_out;
    logic        m_drop;
    logic [31:0] m_req_addr;
    int unsigned m_fetch;
    int unsigned m_dropped;

    fetch_stage #(
        .RESET_PC       (RST_PC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_next_pc  = RST_PC;
        m_out      = 1'b0;
        m_drop     = 1'b0;
        m_req_addr = RST_PC;
        m_fetch    = 0;
        m_dropped  = 0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, check state against the model, advance model, step edge.
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic want_resp,
                         input logic [31:0] rdata, input logic ready);
        logic resp;
        logic pop;
        logic issue;
        logic [63:0] front;
        resp           = want_resp && m_out;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_resp      = resp;
        imem_rdata     = rdata;
        if_ready       = ready;

        chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            front = m_q[0];
            chk("if_pc", if_pc, front[63:32]);
            chk("if_instr", if_instr, front[31:0]);
        end
        chk("imem_read", 32'(imem_read), 32'(m_out));
        if (m_out) begin
            chk("imem_address", imem_address, m_req_addr);
        end

        pop   = (m_q.size() > 0) && ready && !redir;
        issue = !m_out && !redir && (m_q.size() < int'(DEPTH));
        if (pop) begin
            void'(m_q.pop_front());
        end
        if (resp) begin
            if (!m_drop && !redir) begin
                m_q.push_back({m_req_addr, rdata});
                m_next_pc = m_next_pc + 32'd4;
                m_fetch++;
            end else begin
                m_dropped++;
            end
            m_out = 1'b0;
        end
        if (redir) begin
            m_q.delete();
            m_next_pc = rpc & ~32'h3;
            if (m_out) begin
                m_drop = 1'b1;
            end
        end
        if (issue) begin
            m_out      = 1'b1;
            m_drop     = 1'b0;
            m_req_addr = m_next_pc;
        end

        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_resp      = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        model_reset();
        do_reset();

        // Reset values
        chk("rst_imem_read", 32'(imem_read), 32'd0);
        chk("rst_imem_address", imem_address, RST_PC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);

        // 1: first fetch, response after 2 cycles
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_read", 32'(imem_read), 32'd1);
        chk("t1_addr", imem_address, 32'h4000_0060);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h0000_0013, 1'b1);
        chk("t1_if_valid", 32'(if_valid), 32'd1);
        chk("t1_if_pc", if_pc, 32'h4000_0060);
        chk("t1_if_instr", if_instr, 32'h0000_0013);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_next_addr", imem_address, 32'h4000_0064);

        // 2: stalled consumer, FIFO fills to depth, then drains
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0);
        end
        chk("t2_no_third_req", 32'(imem_read), 32'd0);
        chk("t2_head_pc", if_pc, 32'h4000_0060);
        cycle(1'b0, '0, 1'b1, '0, 1'b1);
        chk("t2_second_pc", if_pc, 32'h4000_0064);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t2_drained", 32'(if_valid), 32'd0);
        chk("t2_resume_addr", imem_address, 32'h4000_0068);
        chk("t2_resume_read", 32'(imem_read), 32'd1);

        // 3: redirect while a request is outstanding
        cycle(1'b1, 32'h4000_1003, 1'b0, '0, 1'b1);
        chk("t3_held_read", 32'(imem_read), 32'd1);
        chk("t3_held_addr", imem_address, 32'h4000_0068);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("t3_discarded", 32'(if_valid), 32'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t3_target_addr", imem_address, 32'h4000_1000);

        // 4: redirect coinciding with the response
        cycle(1'b1, 32'h4000_2000, 1'b1, 32'hBAD0_0001, 1'b1);
        chk("t4_not_pushed", 32'(if_valid), 32'd0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t4_target_addr", imem_address, 32'h4000_2000);

        // 5: PC wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h0BAD_0BAD, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t5_top_addr", imem_address, 32'hFFFF_FFFC);
        cycle(1'b0, '0, 1'b1, 32'h0000_0011, 1'b0);
        chk("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t5_wrap_addr", imem_address, 32'h0000_0000);

        // 6: asynchronous reset mid-request with a packet buffered
        chk("t6_pre_valid", 32'(if_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_read", 32'(imem_read), 32'd0);
        chk("t6_async_valid", 32'(if_valid), 32'd0);
        chk("t6_async_addr", imem_address, RST_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t6_first_addr", imem_address, RST_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r_redir;
            logic [31:0] r_pc;
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom());
            cycle(r_redir, r_pc, ($urandom_range(0, 2) != 0), 32'($urandom()),
                  ($urandom_range(0, 3) != 0));
        end

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'(m_fetch));
        chk("drop_count", drop_count, 32'(m_dropped));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
